// File: rtl/clock_ui_pkg.sv
// Shared encodings for the keypad clock user interface.
// Key codes, state encodings, target codes and commit enables.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TGT_SETCLOCK  = 2'd0,
        TGT_STOPWATCH = 2'd1,
        TGT_ALARM     = 2'd2
    } target_e;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    localparam logic [3:0] EN_SETCLOCK  = 4'b0100;
    localparam logic [3:0] EN_STOPWATCH = 4'b0010;
    localparam logic [3:0] EN_ALARM     = 4'b0001;

    localparam int unsigned NUM_DIGITS = 6;

    function automatic logic [3:0] target_enable(input logic [1:0] tgt);
        logic [3:0] en;
        en = 4'b0000;
        case (tgt)
            TGT_SETCLOCK:  en = EN_SETCLOCK;
            TGT_STOPWATCH: en = EN_STOPWATCH;
            TGT_ALARM:     en = EN_ALARM;
            default:       en = 4'b0000;
        endcase
        return en;
    endfunction

    function automatic logic [1:0] target_next(input logic [1:0] tgt);
        return (tgt == TGT_ALARM) ? TGT_SETCLOCK : tgt + 2'd1;
    endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a 24-bit BCD HHMMSS value.
// Valid when every nibble <= 9, hours <= 23, minute/second tens <= 5.
module bcd_time_check (
    input  logic [23:0] bcd,
    output logic        valid
);

    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       nib_ok;
    logic       hour_ok;

    assign {h1, h0, m1, m0, s1, s0} = bcd;

    always_comb begin
        nib_ok = (h1 <= 4'd9) && (h0 <= 4'd9) && (m1 <= 4'd9)
              && (m0 <= 4'd9) && (s1 <= 4'd9) && (s0 <= 4'd9);
        hour_ok = (h1 < 4'd2) || ((h1 == 4'd2) && (h0 <= 4'd3));
        valid = nib_ok && hour_ok && (m1 <= 4'd5) && (s1 <= 4'd5);
    end

endmodule

// File: rtl/keypad_entry_sequencer.sv
// Keypad strobes to 6-digit BCD time entries with one-hot commit enable.
// Optional idle abort of an open entry when ENTRY_TIMEOUT_EN is defined.
module keypad_entry_sequencer
    import clock_ui_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mode_btn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [23:0] keypad_clock,
    output logic [3:0]  enable,
    output logic [1:0]  target,
    output logic [2:0]  digit_cnt,
    output logic        entry_active,
    output logic        err
);

    state_e      state_q, state_d;
    logic [23:0] buf_q, buf_d;
    logic [3:0]  enable_q, enable_d;
    logic [1:0]  target_q, target_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        is_digit;
    logic        time_ok;

    assign is_digit = key_valid && (key_code <= 4'd9);

    bcd_time_check u_check (
        .bcd   (buf_q),
        .valid (time_ok)
    );

`ifdef ENTRY_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        enable_d = 4'b0000;
        err_d    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        tmo_d    = 32'd0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (is_digit) begin
                    buf_d   = {20'h0, key_code};
                    cnt_d   = 3'd1;
                    state_d = ST_ENTRY;
                end else if (mode_btn) begin
                    target_d = target_next(target_q);
                end
            end
            ST_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                tmo_d = tmo_q + 32'd1;
`endif
                unique case (1'b1)
                    is_digit: begin
                        if (cnt_q < 3'(NUM_DIGITS)) begin
                            buf_d = {buf_q[19:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    key_valid && (key_code == KEY_CLEAR): begin
                        buf_d   = 24'h0;
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                    key_valid && (key_code == KEY_ENTER): begin
                        if (cnt_q == 3'(NUM_DIGITS)) begin
                            state_d = ST_CHECK;
                        end else begin
                            err_d   = 1'b1;
                            buf_d   = 24'h0;
                            cnt_d   = 3'd0;
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
`ifdef ENTRY_TIMEOUT_EN
                // Any accepted key restarts the idle window.
                if (key_valid) begin
                    tmo_d = 32'd0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = 32'd0;
                    err_d   = 1'b1;
                    buf_d   = 24'h0;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_CHECK: begin
                // Enable is registered here so it lines up with COMMIT.
                if (time_ok) begin
                    enable_d = target_enable(target_q);
                    state_d  = ST_COMMIT;
                end else begin
                    err_d   = 1'b1;
                    buf_d   = 24'h0;
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            buf_q    <= 24'h0;
            target_q <= TGT_SETCLOCK;
            cnt_q    <= 3'd0;
            enable_q <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            err_q    <= err_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign keypad_clock = buf_q;
    assign enable       = enable_q;
    assign target       = target_q;
    assign digit_cnt    = cnt_q;
    assign entry_active = (state_q == ST_ENTRY);
    assign err          = err_q;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Randomized scoreboard bench for keypad_entry_sequencer.
// Define ENTRY_TIMEOUT_EN to also exercise the idle abort.
module tb_keypad_entry_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mode_btn;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [23:0] keypad_clock;
    logic [3:0]  enable;
    logic [1:0]  target;
    logic [2:0]  digit_cnt;
    logic        entry_active;
    logic        err;

    always #5 clk = ~clk;

`ifdef ENTRY_TIMEOUT_EN
    keypad_entry_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
    keypad_entry_sequencer dut (
`endif
        .clk          (clk),
        .resetn       (resetn),
        .mode_btn     (mode_btn),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .keypad_clock (keypad_clock),
        .enable       (enable),
        .target       (target),
        .digit_cnt    (digit_cnt),
        .entry_active (entry_active),
        .err          (err)
    );

    typedef struct packed {
        logic [3:0]  en;
        logic        er;
        logic [23:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int          digs[$];
    int          m_target;
    bit          m_active;
    logic [23:0] m_buf;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] pack_digs();
        logic [23:0] v;
        v = 24'h0;
        foreach (digs[i]) v = (v << 4) | 24'(digs[i]);
        return v;
    endfunction

    function automatic logic [3:0] onehot(input int t);
        return (t == 0) ? 4'b0100 : (t == 1) ? 4'b0010 : 4'b0001;
    endfunction

    task automatic cycle(input bit m, input bit kv, input logic [3:0] kc);
        mode_btn  = m;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        @(negedge clk);
        mode_btn  = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic model_reset();
        digs.delete();
        m_target = 0;
        m_active = 0;
        m_buf    = 24'h0;
    endtask

    task automatic press(input bit m, input bit kv, input logic [3:0] kc);
        bit entered;
        entered = 0;
        if (!m_active) begin
            if (kv && kc <= 4'd9) begin
                digs.delete();
                digs.push_back(int'(kc));
                m_active = 1;
                m_buf    = pack_digs();
            end else if (m) begin
                m_target = (m_target + 1) % 3;
            end
        end else if (kv) begin
            if (kc <= 4'd9) begin
                if (digs.size() < 6) digs.push_back(int'(kc));
                m_buf = pack_digs();
            end else if (kc == 4'hA) begin
                digs.delete();
                m_active = 0;
                m_buf    = 24'h0;
            end else if (kc == 4'hB) begin
                entered = 1;
                if (digs.size() == 6) begin
                    int hh, mm, ss;
                    hh = digs[0] * 10 + digs[1];
                    mm = digs[2] * 10 + digs[3];
                    ss = digs[4] * 10 + digs[5];
                    if (hh <= 23 && mm <= 59 && ss <= 59) begin
                        m_buf = pack_digs();
                        exp_q.push_back({onehot(m_target), 1'b0, m_buf});
                    end else begin
                        m_buf = 24'h0;
                        exp_q.push_back({4'b0000, 1'b1, 24'h0});
                    end
                end else begin
                    m_buf = 24'h0;
                    exp_q.push_back({4'b0000, 1'b1, 24'h0});
                end
                digs.delete();
                m_active = 0;
            end
        end
        cycle(m, kv, kc);
        if (entered) repeat (3) cycle(0, 0, 4'h0);
        chk("keypad_clock", 32'(keypad_clock), 32'(m_buf));
        chk("digit_cnt", 32'(digit_cnt), 32'(digs.size()));
        chk("entry_active", 32'(entry_active), 32'(m_active));
        chk("target", 32'(target), 32'(m_target));
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) press(0, 1, seq[i]);
    endtask

    always @(negedge clk) begin
        if (resetn && (enable != 4'b0000 || err)) begin
            chk("enable_legal",
                32'(enable inside {4'b0000, 4'b0001, 4'b0010, 4'b0100}), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual en=%b err=%b required none",
                         enable, err);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("enable", 32'(enable), 32'(e.en));
                chk("err", 32'(err), 32'(e.er));
                chk("commit_value", 32'(keypad_clock), 32'(e.val));
            end
        end
    end

    function automatic logic [3:0] rand_digit(input int n);
        if ($urandom_range(3) == 0) return 4'($urandom_range(9));
        case (n)
            0:       return 4'($urandom_range(2));
            1:       return (digs[0] == 2) ? 4'($urandom_range(3))
                                           : 4'($urandom_range(9));
            2, 4:    return 4'($urandom_range(5));
            default: return 4'($urandom_range(9));
        endcase
    endfunction

    initial begin
        resetn    = 1'b0;
        mode_btn  = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_keypad_clock", 32'(keypad_clock), 32'h0);
        chk("rst_enable", 32'(enable), 32'h0);
        chk("rst_target", 32'(target), 32'h0);
        chk("rst_digit_cnt", 32'(digit_cnt), 32'h0);
        chk("rst_entry_active", 32'(entry_active), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB});
        chk("t1_value", 32'(keypad_clock), 32'h123456);

        press(1, 0, 4'h0);
        press(1, 0, 4'h0);
        chk("t2_target", 32'(target), 32'd2);
        keys('{4'h2, 4'h3, 4'h5, 4'h9, 4'h5, 4'h9, 4'hB});
        chk("t2_value", 32'(keypad_clock), 32'h235959);

        keys('{4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB});
        chk("t3_value", 32'(keypad_clock), 32'h0);

        press(1, 0, 4'h0);
        press(1, 0, 4'h0);
        keys('{4'h1, 4'h2, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hB});
        chk("t4_value", 32'(keypad_clock), 32'h000010);

        keys('{4'h1, 4'h2, 4'h3, 4'hB});
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB});
        chk("t5_drop7", 32'(keypad_clock), 32'h123456);
        press(0, 1, 4'h4);
        press(1, 0, 4'h0);
        chk("t5_mode_in_entry", 32'(target), 32'd1);
        press(0, 1, 4'hA);
        press(1, 1, 4'h5);
        chk("t5_mode_and_digit", 32'(target), 32'd1);
        press(0, 1, 4'hA);

        keys('{4'h1, 4'h2, 4'h3});
        resetn = 1'b0;
        #1;
        chk("mid_rst_keypad_clock", 32'(keypad_clock), 32'h0);
        chk("mid_rst_target", 32'(target), 32'h0);
        chk("mid_rst_digit_cnt", 32'(digit_cnt), 32'h0);
        chk("mid_rst_entry_active", 32'(entry_active), 32'h0);
        chk("mid_rst_enable", 32'(enable), 32'h0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 55)      press(0, 1, rand_digit(digs.size()));
            else if (r < 70) press(0, 1, 4'hB);
            else if (r < 75) press(0, 1, 4'hA);
            else if (r < 85) press(1, 0, 4'h0);
            else if (r < 90) press(0, 1, 4'($urandom_range(15, 12)));
            else if (r < 93) press(1, 1, rand_digit(digs.size()));
            else             cycle(0, 0, 4'h0);
        end

        press(0, 1, 4'hA);
`ifdef ENTRY_TIMEOUT_EN
        keys('{4'h1, 4'h2, 4'h3});
        exp_q.push_back({4'b0000, 1'b1, 24'h0});
        repeat (20) cycle(0, 0, 4'h0);
        model_reset();
        chk("tmo_entry_active", 32'(entry_active), 32'h0);
        chk("tmo_keypad_clock", 32'(keypad_clock), 32'h0);
        chk("tmo_digit_cnt", 32'(digit_cnt), 32'h0);
`endif

        repeat (5) @(negedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
